cond_unit: RTL and testbench

- Consumer end of the ALU flag interface. Holds the architectural NZCV flag register written from the ALU's N, Z, C and V outputs.
- Evaluates each instruction's 4-bit condition code against the stored flags.
- Gates the instruction's register-write, memory-write and PC-write strobes.
- Sits between the decoder and the datapath. Keeps saturating counters of executed and squashed instructions for debug.

---
 rtl/cond_unit.sv | 126 ++++++++++++
 tb/tb_cond_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flag register, evaluates condition
// codes against it, gates the write strobes and keeps debug execute/squash counters.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             cnt_clr,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] exec_cnt,
    output logic [CNT_W-1:0] squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]       flags_r;
    logic [3:0]       flags_next_s;
    logic [CNT_W-1:0] exec_cnt_r;
    logic [CNT_W-1:0] squash_cnt_r;
    logic             pass_s;
    logic             condex_s;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = ~z & (n == v);
            4'b1101: r = z | (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Condition evaluation on the stored flags; reset forces every strobe low.
    always_comb begin
        pass_s   = cond_pass(Cond, flags_r);
        condex_s = valid_i & pass_s & reset;
    end

    // Next flag value: each half loads independently, only for an executed instruction.
    always_comb begin
        flags_next_s = flags_r;
        if (condex_s) begin
            if (FlagW[1]) begin
                flags_next_s[3:2] = ALUFlags[3:2];
            end else begin
                flags_next_s[3:2] = flags_r[3:2];
            end
            if (FlagW[0]) begin
                flags_next_s[1:0] = ALUFlags[1:0];
            end else begin
                flags_next_s[1:0] = flags_r[1:0];
            end
        end else begin
            flags_next_s = flags_r;
        end
    end

    // Architectural flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_r <= 4'b0000;
        end else begin
            flags_r <= flags_next_s;
        end
    end

    // Saturating debug counters; a clear wins over the instruction in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exec_cnt_r   <= '0;
            squash_cnt_r <= '0;
        end else if (cnt_clr) begin
            exec_cnt_r   <= '0;
            squash_cnt_r <= '0;
        end else if (valid_i) begin
            if (condex_s) begin
                if (exec_cnt_r != CNT_MAX) begin
                    exec_cnt_r <= exec_cnt_r + CNT_ONE;
                end
            end else begin
                if (squash_cnt_r != CNT_MAX) begin
                    squash_cnt_r <= squash_cnt_r + CNT_ONE;
                end
            end
        end
    end

    assign CondEx     = condex_s;
    assign PCSrc      = PCS & condex_s;
    assign RegWrite   = RegW & condex_s & ~NoWrite;
    assign MemWrite   = MemW & condex_s;
    assign Flags      = flags_r;
    assign exec_cnt   = exec_cnt_r;
    assign squash_cnt = squash_cnt_r;

endmodule

// File: tb/tb_cond_unit.sv
// Scoreboard bench for cond_unit: directed scenarios plus randomized traffic
// checked against an instruction-level reference model.
module tb_cond_unit;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    logic valid_i, PCS, RegW, MemW, NoWrite, cnt_clr;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0] Flags;
    logic [CNT_W-1:0] exec_cnt, squash_cnt;

    typedef struct {
        logic condex, pcsrc, regwrite, memwrite;
        logic [3:0] flags;
        int ex, sq;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    logic [3:0] m_flags;
    int m_ex, m_sq;

    cond_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .Cond(Cond), .ALUFlags(ALUFlags),
        .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .cnt_clr(cnt_clr), .PCSrc(PCSrc), .RegWrite(RegWrite), .MemWrite(MemWrite),
        .CondEx(CondEx), .Flags(Flags), .exec_cnt(exec_cnt), .squash_cnt(squash_cnt)
    );

    always #5 clk = ~clk;

    // Condition codes come in pairs: the odd code is the inverse of the even one.
    function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of stimulus, predict outputs, advance the model past the next edge.
    task automatic issue(input bit v, input logic [3:0] c, input logic [3:0] af,
                         input logic [1:0] fw, input bit pcs, input bit rw,
                         input bit mw, input bit nw, input bit clr);
        exp_t e;
        bit pass;
        @(posedge clk); #1;
        reset = 1'b1;
        valid_i = v; Cond = v ? c : 4'bxxxx; ALUFlags = af; FlagW = fw;
        PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw; cnt_clr = clr;
        pass = v && ref_pass(c, m_flags);
        e.condex = pass; e.pcsrc = pcs && pass; e.regwrite = rw && pass && !nw;
        e.memwrite = mw && pass; e.flags = m_flags; e.ex = m_ex; e.sq = m_sq;
        sb_q.push_back(e);
        if (pass) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
        end
        if (clr) begin
            m_ex = 0; m_sq = 0;
        end else if (v) begin
            if (pass) m_ex = (m_ex < CMAX) ? m_ex + 1 : CMAX;
            else      m_sq = (m_sq < CMAX) ? m_sq + 1 : CMAX;
        end
    endtask

    task automatic simple(input logic [3:0] c);
        issue(1'b1, c, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle();
        issue(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges with a live instruction on the inputs.
    task automatic mid_reset();
        exp_t e;
        @(posedge clk); #1;
        reset = 1'b0;
        valid_i = 1'b1; Cond = 4'b1110; ALUFlags = 4'hF; FlagW = 2'b11;
        PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; NoWrite = 1'b0; cnt_clr = 1'b0;
        m_flags = 4'b0000; m_ex = 0; m_sq = 0;
        e.condex = 1'b0; e.pcsrc = 1'b0; e.regwrite = 1'b0; e.memwrite = 1'b0;
        e.flags = 4'b0000; e.ex = 0; e.sq = 0;
        sb_q.push_back(e);
        #1;
        check("midrst_flags", int'(Flags), 0);
        check("midrst_exec", int'(exec_cnt), 0);
        check("midrst_condex", int'(CondEx), 0);
    endtask

    task automatic at_sample();
        @(negedge clk); #1;
    endtask

    // Monitor: pop one prediction per presented cycle and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_condex", int'(CondEx), int'(e.condex));
                check("sb_pcsrc", int'(PCSrc), int'(e.pcsrc));
                check("sb_regwrite", int'(RegWrite), int'(e.regwrite));
                check("sb_memwrite", int'(MemWrite), int'(e.memwrite));
                check("sb_flags", int'(Flags), int'(e.flags));
                check("sb_exec", int'(exec_cnt), e.ex);
                check("sb_squash", int'(squash_cnt), e.sq);
            end
        end
    end

    initial begin
        reset = 1'b0; valid_i = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0; cnt_clr = 1'b0;
        m_flags = 4'b0000; m_ex = 0; m_sq = 0;
        #2;
        check("rst_flags", int'(Flags), 0);
        check("rst_exec", int'(exec_cnt), 0);
        check("rst_squash", int'(squash_cnt), 0);

        // Basic pass/fail on reset flags
        simple(4'b0000);                                   at_sample(); check("eq_fail", int'(CondEx), 0);
        issue(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        at_sample(); check("al_regwrite", int'(RegWrite), 1); check("squash_one", int'(squash_cnt), 1);
        issue(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_sample(); check("exec_one", int'(exec_cnt), 1);
        issue(1'b1, 4'b0000, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        at_sample(); check("flags_z", int'(Flags), 4'b0100); check("eq_memwrite", int'(MemWrite), 1);
        simple(4'b0001);                                   at_sample(); check("ne_fail", int'(CondEx), 0);

        // Independent flag halves
        issue(1'b1, 4'b1110, 4'b1011, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(1'b1, 4'b1110, 4'b1000, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        at_sample(); check("flags_cv", int'(Flags), 4'b0111);
        simple(4'b1010); at_sample(); check("flags_nz", int'(Flags), 4'b1011); check("ge_pass", int'(CondEx), 1);
        simple(4'b1100); at_sample(); check("gt_pass", int'(CondEx), 1);
        simple(4'b1001); at_sample(); check("ls_fail", int'(CondEx), 0);

        // Failed instruction must not write flags
        mid_reset();
        issue(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        at_sample(); check("fail_regwrite", int'(RegWrite), 0); check("fail_pcsrc", int'(PCSrc), 0);
        idle(); at_sample(); check("fail_noflags", int'(Flags), 0);

        // Saturation and clear priority
        issue(1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) simple(4'b1110);
        idle(); at_sample(); check("exec_sat", int'(exec_cnt), CMAX);
        issue(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(); at_sample(); check("clr_exec", int'(exec_cnt), 0); check("clr_squash", int'(squash_cnt), 0);

        // Mid-stream reset then never / NoWrite / NE
        mid_reset();
        simple(4'b1111); at_sample(); check("nv_fail", int'(CondEx), 0);
        issue(1'b1, 4'b1110, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        at_sample(); check("nowrite_regwrite", int'(RegWrite), 0); check("nowrite_condex", int'(CondEx), 1);
        simple(4'b0001); at_sample(); check("ne_after_rst", int'(CondEx), 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                mid_reset();
            end else begin
                issue($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
                      1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                      $urandom_range(0, 15) == 0);
            end
        end
        idle();
        repeat (2) @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
